// File: rtl/clock_step_ctrl.sv
// Run/halt/single-step sequencer producing a synchronous CPU clock enable.
// Optional breakpoint support is enabled by defining CLK_CTRL_BRK_EN.
module clock_step_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [DIV_W-1:0] cmd_div,
  output logic             cpu_clk_en,
  output logic             busy,
  output logic             done
`ifdef CLK_CTRL_BRK_EN
  ,
  input  logic             brk_hit,
  output logic             brk_flag
`endif
);

  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] dcnt;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] rem;
  logic             brk_c;
  logic             accept;
  logic             last_step;

`ifdef CLK_CTRL_BRK_EN
  assign brk_c = brk_hit;
`else
  assign brk_c = 1'b0;
`endif

  // A step in progress cannot be interrupted; a breakpoint also blocks commands.
  assign cmd_ready  = (state != S_STEP) && !brk_c;
  assign accept     = cmd_valid && cmd_ready;
  assign cpu_clk_en = (state != S_HALT) && (dcnt == div_q);
  assign busy       = (state != S_HALT);
  assign last_step  = (state == S_STEP) && cpu_clk_en && (rem == CNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_HALT;
      dcnt  <= '0;
      div_q <= '0;
      rem   <= '0;
      done  <= 1'b0;
`ifdef CLK_CTRL_BRK_EN
      brk_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != S_HALT) begin
        dcnt <= (dcnt == div_q) ? '0 : dcnt + DIV_W'(1);
      end
      // rem is at least 1 whenever STEP issues an enable
      if ((state == S_STEP) && cpu_clk_en) begin
        rem <= rem - CNT_W'(1);
      end

      if (brk_c && (state != S_HALT)) begin
        state <= S_HALT;
`ifdef CLK_CTRL_BRK_EN
        brk_flag <= 1'b1;
`endif
      end else if (accept) begin
`ifdef CLK_CTRL_BRK_EN
        brk_flag <= 1'b0;
`endif
        case (cmd_op)
          OP_RUN: begin
            state <= S_RUN;
            div_q <= cmd_div;
            dcnt  <= '0;
          end
          OP_STEP: begin
            div_q <= cmd_div;
            dcnt  <= '0;
            rem   <= cmd_count;
            if (cmd_count == '0) begin
              state <= S_HALT;
              done  <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end
          default: state <= S_HALT;
        endcase
      end else if (last_step) begin
        state <= S_HALT;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed self-checking bench for clock_step_ctrl.
module tb_clock_step_ctrl;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic [7:0]  cmd_div;
  logic        cpu_clk_en;
  logic        busy;
  logic        done;
`ifdef CLK_CTRL_BRK_EN
  logic        brk_hit;
  logic        brk_flag;
`endif

  int errors = 0;
  int checks = 0;

  clock_step_ctrl #(.CNT_W(16), .DIV_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .cmd_div    (cmd_div),
    .cpu_clk_en (cpu_clk_en),
    .busy       (busy),
    .done       (done)
`ifdef CLK_CTRL_BRK_EN
    ,
    .brk_hit    (brk_hit),
    .brk_flag   (brk_flag)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  // Present a command for one edge; on return we are in cycle 0 after accept.
  task automatic send(input logic [1:0] op, input logic [15:0] cnt, input logic [7:0] dv);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_div   = dv;
    step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step_clk();
    step_clk();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL reset_en cyc=%0d got=%b exp=0", i, cpu_clk_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, cmd_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done cyc=%0d got=%b exp=0", i, done); end
      step_clk();
    end
  endtask

  task automatic test_run_div0();
    send(2'd1, 16'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (cpu_clk_en !== 1'b1) begin errors++; $display("FAIL run0_en cyc=%0d got=%b exp=1", i, cpu_clk_en); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run0_busy cyc=%0d got=%b exp=1", i, busy); end
      if (i < 7) step_clk();
    end
    send(2'd0, 16'd0, 8'd0);
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL run0_halt_en got=%b exp=0", cpu_clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run0_halt_busy got=%b exp=0", busy); end
  endtask

  task automatic test_run_div3();
    int pulses = 0;
    logic exp_en;
    send(2'd1, 16'd0, 8'd3);
    cmd_div = 8'd0;  // must be ignored until next accept
    for (int i = 0; i < 16; i++) begin
      exp_en = ((i % 4) == 3);
      checks++; if (cpu_clk_en !== exp_en) begin errors++; $display("FAIL run3_en cyc=%0d got=%b exp=%b", i, cpu_clk_en, exp_en); end
      if (cpu_clk_en === 1'b1) pulses++;
      step_clk();
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL run3_pulses got=%0d exp=4", pulses); end
    send(2'd3, 16'd0, 8'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run3_op3_busy got=%b exp=0", busy); end
  endtask

  task automatic test_step();
    int pulses = 0;
    logic exp_en;
    send(2'd2, 16'd5, 8'd1);
    for (int i = 0; i < 10; i++) begin
      exp_en = ((i % 2) == 1);
      checks++; if (cpu_clk_en !== exp_en) begin errors++; $display("FAIL step_en cyc=%0d got=%b exp=%b", i, cpu_clk_en, exp_en); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL step_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL step_done_early cyc=%0d got=%b exp=0", i, done); end
      if (cpu_clk_en === 1'b1) pulses++;
      step_clk();
    end
    checks++; if (pulses !== 5) begin errors++; $display("FAIL step_pulses got=%0d exp=5", pulses); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL step_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step_busy_end got=%b exp=0", busy); end
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL step_en_end got=%b exp=0", cpu_clk_en); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL step_ready_end got=%b exp=1", cmd_ready); end
    step_clk();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL step_done_width got=%b exp=0", done); end
    // zero-count step: no enable, done in cycle 0
    send(2'd2, 16'd0, 8'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL step0_done got=%b exp=1", done); end
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL step0_en got=%b exp=0", cpu_clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step0_busy got=%b exp=0", busy); end
    step_clk();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL step0_done_width got=%b exp=0", done); end
  endtask

  task automatic test_step_from_run();
    send(2'd1, 16'd0, 8'd0);
    step_clk();
    send(2'd2, 16'd3, 8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (cpu_clk_en !== 1'b1) begin errors++; $display("FAIL runstep_en cyc=%0d got=%b exp=1", i, cpu_clk_en); end
      step_clk();
    end
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL runstep_extra_en got=%b exp=0", cpu_clk_en); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL runstep_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL runstep_busy got=%b exp=0", busy); end
    step_clk();
    // HALT while halted has no effect
    send(2'd0, 16'd0, 8'd0);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL halt_idle busy=%b done=%b ready=%b exp=0,0,1", busy, done, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_step();
    send(2'd2, 16'd100, 8'd0);
    for (int i = 0; i < 20; i++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done_pre cyc=%0d got=%b exp=0", i, done); end
      step_clk();
    end
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got=%b exp=0", cpu_clk_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (done !== 1'b0 || cpu_clk_en !== 1'b0) begin
        errors++; $display("FAIL rstmid_after cyc=%0d done=%b en=%b exp=0,0", i, done, cpu_clk_en);
      end
      step_clk();
    end
  endtask

`ifdef CLK_CTRL_BRK_EN
  task automatic test_brk();
    brk_hit = 1'b1;
    step_clk();
    brk_hit = 1'b0;
    checks++; if (brk_flag !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL brk_halt_ignored flag=%b busy=%b exp=0,0", brk_flag, busy);
    end
    send(2'd1, 16'd0, 8'd0);
    for (int i = 0; i < 6; i++) step_clk();
    brk_hit   = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_count = 16'd7;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL brk_ready got=%b exp=0", cmd_ready); end
    checks++; if (cpu_clk_en !== 1'b1) begin errors++; $display("FAIL brk_en_same got=%b exp=1", cpu_clk_en); end
    step_clk();
    brk_hit   = 1'b0;
    cmd_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_busy got=%b exp=0", busy); end
    checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL brk_en got=%b exp=0", cpu_clk_en); end
    checks++; if (brk_flag !== 1'b1) begin errors++; $display("FAIL brk_flag got=%b exp=1", brk_flag); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL brk_done got=%b exp=0", done); end
    step_clk();
    checks++; if (brk_flag !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL brk_sticky flag=%b done=%b exp=1,0", brk_flag, done);
    end
    send(2'd1, 16'd0, 8'd0);
    checks++; if (brk_flag !== 1'b0) begin errors++; $display("FAIL brk_clear got=%b exp=0", brk_flag); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_rerun got=%b exp=1", busy); end
    send(2'd0, 16'd0, 8'd0);
  endtask
`endif

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_count = 16'd0;
    cmd_div   = 8'd0;
`ifdef CLK_CTRL_BRK_EN
    brk_hit   = 1'b0;
`endif
    test_reset();
    test_run_div0();
    test_run_div3();
    test_step();
    test_step_from_run();
    test_reset_mid_step();
`ifdef CLK_CTRL_BRK_EN
    test_brk();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
